wavepool_entry_drainer: RTL

WAVEPOOL_ENTRY_DRAINER -- requirements
Module: wavepool_entry_drainer

---
 rtl/wavepool_entry_drainer.sv | 115 +++++++++++
 1 files changed

// File: rtl/wavepool_entry_drainer.sv
// rtl/wavepool_entry_drainer.sv - round-robin drainer of pending entries in a 40-entry store
// Optional occupancy counter compiled in with WAVEPOOL_DRAIN_OCC_EN.
module wavepool_entry_drainer (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic        flush,
    output logic [5:0]  rd_addr,
    input  logic [34:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [34:0] out_data,
    output logic [5:0]  out_addr,
    output logic [5:0]  occupancy
);

    localparam int N = 40;

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t        state;
    logic [N-1:0]  pending;
    logic [N-1:0]  pend_next;
    logic [5:0]    rr_ptr;
    logic [5:0]    sel;
    logic [6:0]    idx;
    logic          found;
    logic          any_pending;
    logic          load;
    logic          valid_next;

    // Circular priority search starting at rr_ptr; idx never exceeds 78 before wrap.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, rr_ptr} + 7'(i);
            if (idx >= 7'd40)
                idx = idx - 7'd40;
            if (!found && pending[idx[5:0]]) begin
                sel   = idx[5:0];
                found = 1'b1;
            end
        end
    end

    assign any_pending = |pending;
    assign rd_addr     = sel;

    // A write that lands on the entry being loaded is applied after the clear, so it stays pending.
    always_comb begin
        load       = ((state == EMPTY) || out_ready) && any_pending;
        pend_next  = pending;
        valid_next = 1'b0;
        if (flush) begin
            pend_next = '0;
        end else begin
            if (load)
                pend_next[sel] = 1'b0;
            if (wr_en && (wr_addr < 6'd40))
                pend_next[wr_addr] = 1'b1;
            valid_next = load || (out_valid && !out_ready);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            pending   <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            pending   <= pend_next;
            out_valid <= valid_next;
            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: if (load) state <= HOLD;
                    HOLD:  if (out_ready && !load) state <= EMPTY;
                    default: state <= EMPTY;
                endcase
                if (load) begin
                    out_data <= rd_data;
                    out_addr <= sel;
                    rr_ptr   <= (sel == 6'd39) ? 6'd0 : sel + 6'd1;
                end
            end
        end
    end

`ifdef WAVEPOOL_DRAIN_OCC_EN
    logic [5:0] occ_next;

    always_comb begin
        occ_next = {5'b0, valid_next};
        for (int i = 0; i < N; i++)
            occ_next = occ_next + {5'b0, pend_next[i]};
    end

    always_ff @(posedge clk) begin
        if (rst)
            occupancy <= '0;
        else
            occupancy <= occ_next;
    end
`else
    assign occupancy = '0;
`endif

endmodule
